// File: rtl/t_lut_acc_pkg.sv
// Shared arithmetic for the T-LUT product accumulators: one lane add with
// overflow detection and optional clamping, sized at elaboration by its arguments.
package t_lut_acc_pkg;

    // Widest accumulator the helper supports. ACC_W must stay below MAX_W so the
    // carry out of the top accumulator bit still fits in a word.
    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        word_t sum;
        logic  ovf;
    } add_res_t;

    // acc and val are already extended to acc_w bits; any bits above acc_w are ignored.
    function automatic add_res_t lane_sat_add(
        input word_t acc,
        input word_t val,
        input int    acc_w,
        input logic  is_signed,
        input logic  saturate
    );
        word_t    mask;
        word_t    sign_bit;
        word_t    lo_acc;
        word_t    lo_val;
        word_t    raw;
        word_t    sum_w;
        logic     sa;
        logic     sb;
        logic     sr;
        add_res_t res;

        mask     = (word_t'(1) << acc_w) - word_t'(1);
        sign_bit = mask & ~(mask >> 1);
        lo_acc   = acc & mask;
        lo_val   = val & mask;
        raw      = lo_acc + lo_val;
        sum_w    = raw & mask;
        sa       = |(lo_acc & sign_bit);
        sb       = |(lo_val & sign_bit);
        sr       = |(sum_w & sign_bit);

        res.sum = sum_w;
        res.ovf = is_signed ? ((sa == sb) && (sr != sa)) : ((raw >> acc_w) != '0);
        if (saturate && res.ovf) begin
            // Signed overflow can only go the way both operands point.
            res.sum = is_signed ? (sa ? sign_bit : (mask >> 1)) : mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: running sum, sticky overflow flag and the output shadow
// that captures the finished window sum when the last beat is accepted.
module acc_lane
    import t_lut_acc_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int ACC_W    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             beat,
    input  logic             last,
    input  logic [IN_W-1:0]  val,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] val_ext;
    logic [ACC_W-1:0] acc_next;
    logic             ovf;
    logic             ovf_next;
    add_res_t         res;
    logic             unused_hi;

    always_comb begin
        // NOTE: every always_comb output gets a value on all paths so no latch is inferred.
        val_ext = ACC_W'(val);
        if (SIGNED != 0) begin
            val_ext = ACC_W'($signed(val));
        end
    end

    assign res       = lane_sat_add(word_t'(acc), word_t'(val_ext), ACC_W,
                                    SIGNED != 0, SATURATE != 0);
    assign acc_next  = res.sum[ACC_W-1:0];
    assign ovf_next  = ovf | res.ovf;
    assign unused_hi = ^(res.sum >> ACC_W);

    // NOTE: the shadow is reset with the live sum because out_sum must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking updates so the shadow captures the pre-edge sum.
            acc     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            if (last) begin
                out_sum <= acc_next;
                out_ovf <= ovf_next;
                acc     <= '0;
                ovf     <= 1'b0;
            end else begin
                acc <= acc_next;
                ovf <= ovf_next;
            end
        end
    end

endmodule

// File: rtl/acc_array_drain.sv
// DIM_C x DIM_A product accumulator array with a one-deep valid/ready output
// shadow, so a new window can start on the cycle after the previous one closes.
module acc_array_drain
    import t_lut_acc_pkg::*;
#(
    parameter int DIM_C    = 4,
    parameter int DIM_A    = 4,
    parameter int IN_W     = 8,
    parameter int ACC_W    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clear,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic                                     in_last,
    input  logic [DIM_C-1:0][DIM_A-1:0][IN_W-1:0]    in_val,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [DIM_C-1:0][DIM_A-1:0][ACC_W-1:0]   out_sum,
    output logic [DIM_C-1:0][DIM_A-1:0]              out_ovf,
    output logic [CNT_W-1:0]                         out_count
);

    logic             accept;
    logic             close_window;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_inc;

    // A shadow being drained this cycle can take the next finished window immediately.
    assign in_ready     = ~out_valid | out_ready;
    assign accept       = in_valid & in_ready & ~clear;
    assign close_window = accept & in_last;
    assign cnt_inc      = (beat_cnt == '1) ? beat_cnt : beat_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            beat_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= in_last ? '0 : cnt_inc;
            end
            if (close_window) begin
                out_count <= cnt_inc;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < DIM_C; c++) begin : g_chan
        for (genvar a = 0; a < DIM_A; a++) begin : g_lane
            acc_lane #(
                .IN_W    (IN_W),
                .ACC_W   (ACC_W),
                .SIGNED  (SIGNED),
                .SATURATE(SATURATE)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .clear  (clear),
                .beat   (accept),
                .last   (in_last),
                .val    (in_val[c][a]),
                .out_sum(out_sum[c][a]),
                .out_ovf(out_ovf[c][a])
            );
        end
    end

endmodule

// File: tb/tb_acc_array_drain.sv
// Scoreboard bench: a default unsigned-wrap 4x4 array plus signed saturating and
// signed wrapping 2x2 arrays with 8-bit sums, all against an integer window model.
module tb_acc_array_drain;

    typedef logic [3:0][3:0][7:0] m_vec_t;
    typedef logic [1:0][1:0][7:0] s_vec_t;

    typedef struct {
        logic [255:0] sum;
        logic [15:0]  ovf;
        int           cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 m_clear, m_in_valid, m_in_ready, m_in_last, m_out_valid, m_out_ready;
    m_vec_t               m_in_val;
    logic [3:0][3:0][15:0] m_out_sum;
    logic [3:0][3:0]      m_out_ovf;
    logic [7:0]           m_out_count;

    logic                 s_clear, s_in_valid, s_in_last, s_out_ready;
    s_vec_t               s_in_val;
    logic                 sa_in_ready, sa_out_valid, sw_in_ready, sw_out_valid;
    s_vec_t               sa_out_sum, sw_out_sum;
    logic [1:0][1:0]      sa_out_ovf, sw_out_ovf;
    logic [7:0]           sa_out_count, sw_out_count;

    acc_array_drain u_main (
        .clk(clk), .rst_n(rst_n), .clear(m_clear),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_last(m_in_last), .in_val(m_in_val),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_sum(m_out_sum), .out_ovf(m_out_ovf), .out_count(m_out_count)
    );

    acc_array_drain #(.DIM_C(2), .DIM_A(2), .IN_W(8), .ACC_W(8), .SIGNED(1), .SATURATE(1), .CNT_W(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(s_clear),
        .in_valid(s_in_valid), .in_ready(sa_in_ready), .in_last(s_in_last), .in_val(s_in_val),
        .out_valid(sa_out_valid), .out_ready(s_out_ready),
        .out_sum(sa_out_sum), .out_ovf(sa_out_ovf), .out_count(sa_out_count)
    );

    acc_array_drain #(.DIM_C(2), .DIM_A(2), .IN_W(8), .ACC_W(8), .SIGNED(1), .SATURATE(0), .CNT_W(8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clear(s_clear),
        .in_valid(s_in_valid), .in_ready(sw_in_ready), .in_last(s_in_last), .in_val(s_in_val),
        .out_valid(sw_out_valid), .out_ready(s_out_ready),
        .out_sum(sw_out_sum), .out_ovf(sw_out_ovf), .out_count(sw_out_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    exp_t qm[$];
    exp_t qa[$];
    exp_t qw[$];

    longint m_acc[16];
    bit     m_ovf[16];
    int     m_cnt;
    longint a_acc[4];
    bit     a_ovf[4];
    longint w_acc[4];
    bit     w_ovf[4];
    int     s_cnt;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Window sum in plain integers: add, test against the representable range, then clamp or wrap.
    function automatic longint model_add(input longint acc, input longint v, input int w,
                                         input bit sgn, input bit sat, output bit ovf);
        longint span;
        longint hi;
        longint lo;
        longint s;
        span = longint'(1) << w;
        hi   = sgn ? span / 2 - 1 : span - 1;
        lo   = sgn ? -(span / 2) : 0;
        s    = acc + v;
        ovf  = (s > hi) || (s < lo);
        if (ovf && sat) begin
            s = (s > hi) ? hi : lo;
        end else if (ovf) begin
            s = s % span;
            if (s < 0) s = s + span;
            if (s > hi) s = s - span;
        end
        return s;
    endfunction

    function automatic m_vec_t fill_m(input logic [7:0] x);
        m_vec_t r;
        for (int c = 0; c < 4; c++) for (int a = 0; a < 4; a++) r[c][a] = x;
        return r;
    endfunction

    function automatic m_vec_t rand_m();
        m_vec_t r;
        for (int c = 0; c < 4; c++) for (int a = 0; a < 4; a++) r[c][a] = 8'($urandom);
        return r;
    endfunction

    function automatic s_vec_t fill_s(input logic [7:0] x);
        s_vec_t r;
        for (int c = 0; c < 2; c++) for (int a = 0; a < 2; a++) r[c][a] = x;
        return r;
    endfunction

    function automatic s_vec_t rand_s();
        s_vec_t r;
        for (int c = 0; c < 2; c++) for (int a = 0; a < 2; a++) r[c][a] = 8'($urandom);
        return r;
    endfunction

    task automatic m_reset_model();
        for (int l = 0; l < 16; l++) begin
            m_acc[l] = 0;
            m_ovf[l] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic s_reset_model();
        for (int l = 0; l < 4; l++) begin
            a_acc[l] = 0;
            a_ovf[l] = 1'b0;
            w_acc[l] = 0;
            w_ovf[l] = 1'b0;
        end
        s_cnt = 0;
    endtask

    task automatic m_model_beat(input m_vec_t v, input bit last);
        exp_t        e;
        bit          o;
        logic [63:0] b;
        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        for (int l = 0; l < 16; l++) begin
            m_acc[l] = model_add(m_acc[l], longint'(v[l/4][l%4]), 16, 1'b0, 1'b0, o);
            m_ovf[l] = m_ovf[l] | o;
        end
        if (last) begin
            e.sum = '0;
            e.ovf = '0;
            e.cnt = m_cnt;
            for (int l = 0; l < 16; l++) begin
                b = m_acc[l];
                e.sum[l*16 +: 16] = b[15:0];
                e.ovf[l] = m_ovf[l];
            end
            qm.push_back(e);
            m_reset_model();
        end
    endtask

    task automatic s_model_beat(input s_vec_t v, input bit last);
        exp_t        ea;
        exp_t        ew;
        bit          o;
        logic [63:0] b;
        longint      x;
        s_cnt = (s_cnt == 255) ? 255 : s_cnt + 1;
        for (int l = 0; l < 4; l++) begin
            x = longint'($signed(v[l/2][l%2]));
            a_acc[l] = model_add(a_acc[l], x, 8, 1'b1, 1'b1, o);
            a_ovf[l] = a_ovf[l] | o;
            w_acc[l] = model_add(w_acc[l], x, 8, 1'b1, 1'b0, o);
            w_ovf[l] = w_ovf[l] | o;
        end
        if (last) begin
            ea.sum = '0; ea.ovf = '0; ea.cnt = s_cnt;
            ew.sum = '0; ew.ovf = '0; ew.cnt = s_cnt;
            for (int l = 0; l < 4; l++) begin
                b = a_acc[l];
                ea.sum[l*8 +: 8] = b[7:0];
                ea.ovf[l] = a_ovf[l];
                b = w_acc[l];
                ew.sum[l*8 +: 8] = b[7:0];
                ew.ovf[l] = w_ovf[l];
            end
            qa.push_back(ea);
            qw.push_back(ew);
            s_reset_model();
        end
    endtask

    // Present one beat and hold it until the handshake completes; on a stall the consumer is released.
    task automatic m_beat(input m_vec_t v, input bit last);
        bit done;
        done       = 1'b0;
        m_in_valid = 1'b1;
        m_in_last  = last;
        m_in_val   = v;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (m_in_ready) begin
                done = 1'b1;
                m_model_beat(v, last);
            end
            tick();
            if (!done) m_out_ready = 1'b1;
        end
        if (!done) check("m_beat_timeout", m_in_ready, 1'b1);
        m_in_valid = 1'b0;
        m_in_last  = 1'b0;
    endtask

    task automatic s_beat(input s_vec_t v, input bit last);
        bit done;
        done       = 1'b0;
        s_in_valid = 1'b1;
        s_in_last  = last;
        s_in_val   = v;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (sa_in_ready && sw_in_ready) begin
                done = 1'b1;
                s_model_beat(v, last);
            end
            tick();
            if (!done) s_out_ready = 1'b1;
        end
        if (!done) check("s_beat_timeout", sa_in_ready & sw_in_ready, 1'b1);
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
    endtask

    task automatic m_clear_cycle(input bit with_beat);
        m_clear    = 1'b1;
        m_in_valid = with_beat;
        m_in_last  = with_beat;
        m_in_val   = rand_m();
        tick();
        m_clear    = 1'b0;
        m_in_valid = 1'b0;
        m_in_last  = 1'b0;
        m_reset_model();
        qm.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m_valid"}, m_out_valid, 1'b0);
        check({tag, "_m_sum"},   m_out_sum,   '0);
        check({tag, "_m_ovf"},   m_out_ovf,   '0);
        check({tag, "_m_count"}, m_out_count, '0);
        check({tag, "_sa_valid"}, sa_out_valid, 1'b0);
        check({tag, "_sa_sum"},   sa_out_sum,   '0);
        check({tag, "_sw_sum"},   sw_out_sum,   '0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        check({tag, "_in_ready"}, m_in_ready, 1'b1);
        m_reset_model();
        s_reset_model();
        qm.delete();
        qa.delete();
        qw.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (rst_n && m_out_valid && m_out_ready) begin
            if (qm.size() == 0) begin
                check("m_spurious_valid", m_out_valid, 1'b0);
            end else begin
                e = qm.pop_front();
                check("m_out_sum",   m_out_sum,   e.sum);
                check("m_out_ovf",   m_out_ovf,   e.ovf);
                check("m_out_count", m_out_count, e.cnt);
            end
        end
    end

    always @(negedge clk) begin : mon_sat
        exp_t e;
        if (rst_n && sa_out_valid && s_out_ready) begin
            if (qa.size() == 0) begin
                check("sa_spurious_valid", sa_out_valid, 1'b0);
            end else begin
                e = qa.pop_front();
                check("sa_out_sum",   sa_out_sum,   e.sum);
                check("sa_out_ovf",   sa_out_ovf,   e.ovf);
                check("sa_out_count", sa_out_count, e.cnt);
            end
        end
    end

    always @(negedge clk) begin : mon_wrap
        exp_t e;
        if (rst_n && sw_out_valid && s_out_ready) begin
            if (qw.size() == 0) begin
                check("sw_spurious_valid", sw_out_valid, 1'b0);
            end else begin
                e = qw.pop_front();
                check("sw_out_sum",   sw_out_sum,   e.sum);
                check("sw_out_ovf",   sw_out_ovf,   e.ovf);
                check("sw_out_count", sw_out_count, e.cnt);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int len;
        m_clear = 1'b0; m_in_valid = 1'b0; m_in_last = 1'b0; m_in_val = '0; m_out_ready = 1'b0;
        s_clear = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_in_val = '0; s_out_ready = 1'b0;
        m_reset_model();
        s_reset_model();

        repeat (2) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check("m_in_ready_after_reset", m_in_ready, 1'b1);
        check("s_in_ready_after_reset", sa_in_ready, 1'b1);

        // Three beats of 200 on every lane.
        m_out_ready = 1'b1;
        m_beat(fill_m(8'd200), 1'b0);
        m_beat(fill_m(8'd200), 1'b0);
        m_beat(fill_m(8'd200), 1'b1);
        repeat (2) tick();

        // Back-to-back two-beat windows with the consumer always ready.
        for (int w = 0; w < 6; w++) begin
            for (int b = 0; b < 2; b++) begin
                check("b2b_in_ready", m_in_ready, 1'b1);
                m_beat(rand_m(), b == 1);
            end
        end
        repeat (2) tick();

        // Backpressure, then drain and reload in the same cycle.
        m_out_ready = 1'b0;
        m_beat(rand_m(), 1'b0);
        m_beat(rand_m(), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", m_in_ready, 1'b0);
            check("bp_out_valid", m_out_valid, 1'b1);
            check("bp_sum_stable", m_out_sum, qm[0].sum);
        end
        tick();
        m_out_ready = 1'b1;
        m_beat(rand_m(), 1'b1);
        check("bp_swap_valid", m_out_valid, 1'b1);
        repeat (2) tick();

        // clear mid-window drops the beat presented with it; then a one-beat window of 5.
        m_beat(rand_m(), 1'b0);
        m_beat(rand_m(), 1'b0);
        m_clear_cycle(1'b1);
        m_beat(fill_m(8'd5), 1'b1);
        repeat (2) tick();
        m_out_ready = 1'b0;
        m_beat(rand_m(), 1'b1);
        check("clr_valid_before", m_out_valid, 1'b1);
        m_clear_cycle(1'b0);
        check("clr_drops_shadow", m_out_valid, 1'b0);
        m_out_ready = 1'b1;

        // 260 beats of 255: the unsigned sum wraps and the beat count saturates at 255.
        for (int b = 0; b < 260; b++) m_beat(fill_m(8'd255), b == 259);
        repeat (2) tick();

        // Asynchronous reset mid-window and mid-drain; the following window starts from zero.
        m_beat(rand_m(), 1'b0);
        async_reset("rst_mid_window");
        m_beat(rand_m(), 1'b1);
        repeat (2) tick();
        m_out_ready = 1'b0;
        m_beat(rand_m(), 1'b1);
        check("rst_drain_valid_before", m_out_valid, 1'b1);
        async_reset("rst_mid_drain");
        m_out_ready = 1'b1;
        m_beat(rand_m(), 1'b0);
        m_beat(rand_m(), 1'b1);

        // Randomised windows, idle cycles and consumer stalls.
        for (int w = 0; w < 40; w++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                m_out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) tick();
                m_beat(rand_m(), b == len - 1);
            end
        end
        m_out_ready = 1'b1;
        repeat (3) tick();

        // Signed 8-bit arrays: 100+100 saturates to 127 or wraps to -56; -100-100 to -128 or 56.
        s_out_ready = 1'b1;
        s_beat(fill_s(8'd100), 1'b0);
        s_beat(fill_s(8'd100), 1'b1);
        s_beat(fill_s(8'd156), 1'b0);
        s_beat(fill_s(8'd156), 1'b1);
        s_beat(fill_s(8'd5), 1'b1);
        for (int w = 0; w < 20; w++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                s_out_ready = ($urandom_range(0, 3) != 0);
                s_beat(rand_s(), b == len - 1);
            end
        end

        m_out_ready = 1'b1;
        s_out_ready = 1'b1;
        repeat (4) tick();
        check("m_scoreboard_empty", qm.size(), 0);
        check("sa_scoreboard_empty", qa.size(), 0);
        check("sw_scoreboard_empty", qw.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
